// File: rtl/fc_seq_layer_if.sv
// fc_seq_layer_if: control, memory-port and output-stream bundle for the fc_seq_layer engine
interface fc_seq_layer_if #(
    parameter int WORD_SIZE = 16,
    parameter int IP_SIZE   = 128,
    parameter int OP_SIZE   = 84
);
    localparam int XAW = (IP_SIZE > 1) ? $clog2(IP_SIZE) : 1;
    localparam int WAW = (OP_SIZE * IP_SIZE + OP_SIZE > 1) ? $clog2(OP_SIZE * IP_SIZE + OP_SIZE) : 1;
    localparam int IW  = (OP_SIZE > 1) ? $clog2(OP_SIZE) : 1;

    logic                 start;
    logic                 relu_en;
    logic                 busy;
    logic                 done;
    logic [XAW-1:0]       x_addr;
    logic [WORD_SIZE-1:0] x_data;
    logic [WAW-1:0]       w_addr;
    logic [WORD_SIZE-1:0] w_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_data;
    logic [IW-1:0]        out_idx;
    logic [IW-1:0]        argmax_idx;

    modport master (
        input  start, relu_en, x_data, w_data, out_ready,
        output busy, done, x_addr, w_addr, out_valid, out_data, out_idx, argmax_idx
    );

    modport slave (
        output start, relu_en, x_data, w_data, out_ready,
        input  busy, done, x_addr, w_addr, out_valid, out_data, out_idx, argmax_idx
    );
endinterface

// File: rtl/fc_seq_layer.sv
// fc_seq_layer: time-multiplexed fully-connected layer with one signed MAC, optional ReLU and running argmax
module fc_seq_layer #(
    parameter int WORD_SIZE = 16,
    parameter int INT_SLICE = 8,
    parameter int IP_SIZE   = 128,
    parameter int OP_SIZE   = 84
) (
    input logic            clk,
    input logic            rst,
    fc_seq_layer_if.master fc
);
    localparam int FRAC  = WORD_SIZE - INT_SLICE;
    localparam int XAW   = (IP_SIZE > 1) ? $clog2(IP_SIZE) : 1;
    localparam int WAW   = (OP_SIZE * IP_SIZE + OP_SIZE > 1) ? $clog2(OP_SIZE * IP_SIZE + OP_SIZE) : 1;
    localparam int IW    = (OP_SIZE > 1) ? $clog2(OP_SIZE) : 1;
    localparam int ACC_W = 2 * WORD_SIZE + $clog2(IP_SIZE) + 1;

    localparam logic [XAW-1:0] K_LAST    = XAW'(IP_SIZE - 1);
    localparam logic [IW-1:0]  J_LAST    = IW'(OP_SIZE - 1);
    localparam logic [WAW-1:0] BIAS_BASE = WAW'(OP_SIZE * IP_SIZE);
    localparam logic [WAW-1:0] IP_W      = WAW'(IP_SIZE);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, EMIT, DONE} state_t;

    state_t                       state_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         relu_q;
    logic                         out_valid_q;
    logic signed [WORD_SIZE-1:0]  out_data_q;
    logic signed [WORD_SIZE-1:0]  max_q;
    logic [IW-1:0]                out_idx_q;
    logic [IW-1:0]                argmax_q;
    logic [IW-1:0]                j_q;
    logic [XAW-1:0]               x_addr_q;
    logic [WAW-1:0]               w_addr_q;
    logic signed [ACC_W-1:0]      acc_q;

    logic signed [2*WORD_SIZE-1:0] prod;
    logic signed [ACC_W-1:0]       bias_ext;
    logic signed [ACC_W-1:0]       acc_d;
    logic signed [ACC_W-1:0]       shifted;
    logic signed [WORD_SIZE-1:0]   sat;
    logic signed [WORD_SIZE-1:0]   act;

    // MAC datapath and the shift/saturate/ReLU applied to the final accumulation
    always_comb begin
        prod     = $signed(fc.x_data) * $signed(fc.w_data);
        bias_ext = {{(ACC_W-WORD_SIZE){fc.w_data[WORD_SIZE-1]}}, fc.w_data} <<< FRAC;
        acc_d    = acc_q + {{(ACC_W-2*WORD_SIZE){prod[2*WORD_SIZE-1]}}, prod};
        shifted  = acc_d >>> FRAC;
        sat      = shifted > SAT_MAX ? SAT_MAX[WORD_SIZE-1:0] :
                   shifted < SAT_MIN ? SAT_MIN[WORD_SIZE-1:0] : shifted[WORD_SIZE-1:0];
        act      = relu_q && sat[WORD_SIZE-1] ? '0 : sat;
    end

    // Sequencer: one neuron per BIAS/MAC/DRAIN/EMIT pass; memory data lags its address by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            max_q       <= '0;
            out_idx_q   <= '0;
            argmax_q    <= '0;
            j_q         <= '0;
            x_addr_q    <= '0;
            w_addr_q    <= '0;
            acc_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fc.start) begin
                        state_q  <= BIAS;
                        busy_q   <= 1'b1;
                        relu_q   <= fc.relu_en;
                        j_q      <= '0;
                        w_addr_q <= BIAS_BASE;
                    end
                end
                BIAS: begin
                    state_q  <= MAC;
                    x_addr_q <= '0;
                    w_addr_q <= WAW'(j_q) * IP_W;
                end
                MAC: begin
                    acc_q <= x_addr_q == '0 ? bias_ext : acc_d;
                    if (x_addr_q == K_LAST) begin
                        state_q  <= DRAIN;
                        x_addr_q <= '0;
                        w_addr_q <= '0;
                    end else begin
                        x_addr_q <= x_addr_q + XAW'(1);
                        w_addr_q <= w_addr_q + WAW'(1);
                    end
                end
                DRAIN: begin
                    state_q     <= EMIT;
                    out_data_q  <= act;
                    out_idx_q   <= j_q;
                    out_valid_q <= 1'b1;
                end
                EMIT: begin
                    if (fc.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (j_q == '0 || out_data_q > max_q) begin
                            max_q    <= out_data_q;
                            argmax_q <= j_q;
                        end
                        if (j_q == J_LAST) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= BIAS;
                            j_q      <= j_q + IW'(1);
                            w_addr_q <= BIAS_BASE + WAW'(j_q) + WAW'(1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fc.busy       = busy_q;
    assign fc.done       = done_q;
    assign fc.x_addr     = x_addr_q;
    assign fc.w_addr     = w_addr_q;
    assign fc.out_valid  = out_valid_q;
    assign fc.out_data   = out_data_q;
    assign fc.out_idx    = out_idx_q;
    assign fc.argmax_idx = argmax_q;
endmodule

// File: tb/tb_fc_seq_layer.sv
// tb_fc_seq_layer: scoreboard bench for fc_seq_layer with an arithmetic reference model
module tb_fc_seq_layer;
    localparam int IP = 4;
    localparam int OP = 2;
    localparam int NW = OP * IP + OP;

    typedef struct packed {
        int          idx;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] xmem [IP];
    logic [15:0] wmem [NW];
    exp_t expq [$];
    int   amq  [$];
    int   compared = 0;
    int   mismatched = 0;
    int   handshakes = 0;
    int   dones = 0;

    fc_seq_layer_if #(.WORD_SIZE(16), .IP_SIZE(IP), .OP_SIZE(OP)) fc ();

    fc_seq_layer #(.WORD_SIZE(16), .INT_SLICE(8), .IP_SIZE(IP), .OP_SIZE(OP)) dut (
        .clk (clk),
        .rst (rst),
        .fc  (fc.master)
    );

    always #5 clk = ~clk;

    // synchronous-read memories feeding the engine
    always @(posedge clk) begin
        fc.x_data <= xmem[fc.x_addr];
        fc.w_data <= wmem[fc.w_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string msg);
        compared++;
        mismatched++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // reference: plain integer dot product, floor shift, clamp, optional ReLU
    function automatic logic [15:0] neuron(input int j, input logic relu);
        longint s;
        s = longint'($signed(wmem[OP*IP+j])) * 256;
        for (int i = 0; i < IP; i++)
            s += longint'($signed(xmem[i])) * longint'($signed(wmem[j*IP+i]));
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic push_expect(input logic relu);
        logic [15:0] v;
        logic [15:0] best;
        int bi;
        bi = 0;
        best = neuron(0, relu);
        for (int j = 0; j < OP; j++) begin
            v = neuron(j, relu);
            expq.push_back('{j, v});
            if ($signed(v) > $signed(best)) begin
                best = v;
                bi = j;
            end
        end
        amq.push_back(bi);
    endtask

    task automatic load_uniform(input logic [15:0] x, input logic [15:0] w0, input logic [15:0] b0,
                                input logic [15:0] w1, input logic [15:0] b1);
        for (int i = 0; i < IP; i++) begin
            xmem[i] = x;
            wmem[i] = w0;
            wmem[IP+i] = w1;
        end
        wmem[OP*IP] = b0;
        wmem[OP*IP+1] = b1;
    endtask

    task automatic load_random(input bit full);
        for (int i = 0; i < IP; i++) xmem[i] = full ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
        for (int i = 0; i < NW; i++) wmem[i] = full ? 16'($urandom) : 16'($urandom_range(0, 1023) - 512);
    endtask

    // ready_mode: 0 always ready, 1 stall five cycles on first output, 2 random ready
    task automatic run_layer(input logic relu, input int ready_mode, input int exp_lat, input bit pulse_busy);
        int n;
        int stall;
        int hs0;
        int dn0;
        bit got;
        push_expect(relu);
        hs0 = handshakes;
        dn0 = dones;
        fc.out_ready = ready_mode != 1;
        fc.relu_en = relu;
        fc.start = 1'b1;
        n = 0;
        stall = 0;
        got = 1'b0;
        while (n < 2000 && !got) begin
            @(posedge clk);
            #1;
            n++;
            fc.start = pulse_busy && (n == 3 || n == 9);
            fc.relu_en = ~relu;
            if (ready_mode == 2) fc.out_ready = $urandom_range(0, 3) != 0;
            if (ready_mode == 1 && fc.out_valid && !fc.out_ready) begin
                if (stall == 5) fc.out_ready = 1'b1;
                else stall++;
            end
            got = fc.done;
        end
        if (!got) begin
            fail("done_timeout", "no done within 2000 cycles");
        end else begin
            if (exp_lat != 0) check("start_to_done", 64'(n), 64'(exp_lat));
            fc.start = pulse_busy;
            @(posedge clk);
            #1;
            fc.start = 1'b0;
            fc.out_ready = 1'b1;
            check("busy_after_done", 64'(fc.busy), 64'd0);
            check("handshakes_per_run", 64'(handshakes - hs0), 64'(OP));
            check("dones_per_run", 64'(dones - dn0), 64'd1);
        end
        fc.start = 1'b0;
        fc.out_ready = 1'b1;
    endtask

    // monitor: pops scoreboard on each accepted output and on done
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (fc.out_valid) begin
                if (fc.out_ready) begin
                    handshakes++;
                    if (expq.size() == 0) begin
                        fail("unexpected_out", $sformatf("idx %0d data %0h", fc.out_idx, fc.out_data));
                    end else begin
                        e = expq.pop_front();
                        check("out_data", 64'(fc.out_data), 64'(e.data));
                        check("out_idx", 64'(fc.out_idx), 64'(e.idx));
                    end
                end else if (expq.size() != 0) begin
                    check("stall_data", 64'(fc.out_data), 64'(expq[0].data));
                    check("stall_idx", 64'(fc.out_idx), 64'(expq[0].idx));
                end
            end
            if (fc.done) begin
                dones++;
                if (amq.size() == 0) fail("unexpected_done", "done with nothing pending");
                else check("argmax_idx", 64'(fc.argmax_idx), 64'(amq.pop_front()));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(fc.busy), 64'd0);
        check({tag, "_done"}, 64'(fc.done), 64'd0);
        check({tag, "_out_valid"}, 64'(fc.out_valid), 64'd0);
        check({tag, "_out_data"}, 64'(fc.out_data), 64'd0);
        check({tag, "_out_idx"}, 64'(fc.out_idx), 64'd0);
        check({tag, "_argmax"}, 64'(fc.argmax_idx), 64'd0);
        check({tag, "_x_addr"}, 64'(fc.x_addr), 64'd0);
        check({tag, "_w_addr"}, 64'(fc.w_addr), 64'd0);
    endtask

    initial begin
        int hs0;
        fc.start = 1'b0;
        fc.relu_en = 1'b0;
        fc.out_ready = 1'b1;
        load_uniform(16'h0100, 16'h0080, 16'h0040, 16'hFF00, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_layer(1'b0, 0, 15, 1'b0);
        run_layer(1'b1, 0, 15, 1'b0);

        load_uniform(16'h7F00, 16'h7F00, 16'h0000, 16'h7F00, 16'h0000);
        run_layer(1'b0, 0, 15, 1'b0);
        load_uniform(16'h7F00, 16'h8100, 16'h0000, 16'h8100, 16'h0000);
        run_layer(1'b0, 0, 15, 1'b0);

        load_uniform(16'h0100, 16'h0080, 16'h0040, 16'hFF00, 16'h0000);
        run_layer(1'b0, 1, 20, 1'b0);

        load_uniform(16'h0100, 16'hFF00, 16'h0000, 16'h0080, 16'h0040);
        run_layer(1'b0, 0, 15, 1'b0);

        hs0 = handshakes;
        load_uniform(16'h0100, 16'h0080, 16'h0040, 16'hFF00, 16'h0000);
        fc.start = 1'b1;
        @(posedge clk);
        #1;
        fc.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midrun_rst");
        repeat (20) @(posedge clk);
        #1;
        check("no_output_after_rst", 64'(handshakes - hs0), 64'd0);
        run_layer(1'b0, 0, 15, 1'b0);

        run_layer(1'b0, 0, 15, 1'b1);

        for (int r = 0; r < 20; r++) begin
            load_random(r % 3 == 0);
            run_layer(1'($urandom_range(0, 1)), (r % 2) ? 2 : 0, (r % 2) ? 0 : 15, r % 4 == 1);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(expq.size() + amq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
